// File: rtl/avalon_ir_encode.sv
// Avalon-MM IR transmitter: loads a 16-bit address and a 16-bit data word, then
// sends one NEC frame (leader, 32 bits LSB-first, stop mark) on a 38 kHz carrier.
module avalon_ir_encode #(
   parameter int CLK_FREQ      = 50000000,
   parameter int CARRIER_HZ    = 38000,
   parameter int LEAD_MARK_US  = 9000,
   parameter int LEAD_SPACE_US = 4500,
   parameter int BIT_MARK_US   = 560,
   parameter int ZERO_SPACE_US = 560,
   parameter int ONE_SPACE_US  = 1690
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [2:0] address,
   input  logic [7:0] writedata,
   input  logic       write,
   input  logic       read,
   input  logic       chipselect,
   output logic [7:0] readdata,
   output logic       oIR,
   output logic       oIR_env,
   output logic       Done_Flag_o
);

   localparam int CYC_PER_US = CLK_FREQ / 1000000;
   localparam int CAR_DIV    = CLK_FREQ / CARRIER_HZ;
   localparam int CAR_THR    = CAR_DIV / 3;

   localparam logic [19:0] LEAD_MARK_CYC  = 20'(LEAD_MARK_US  * CYC_PER_US);
   localparam logic [19:0] LEAD_SPACE_CYC = 20'(LEAD_SPACE_US * CYC_PER_US);
   localparam logic [19:0] BIT_MARK_CYC   = 20'(BIT_MARK_US   * CYC_PER_US);
   localparam logic [19:0] ZERO_SPACE_CYC = 20'(ZERO_SPACE_US * CYC_PER_US);
   localparam logic [19:0] ONE_SPACE_CYC  = 20'(ONE_SPACE_US  * CYC_PER_US);

   typedef enum logic [2:0] {
      IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK
   } state_t;

   state_t      state, next_state;
   logic [19:0] phase_cnt;
   logic [19:0] phase_len;
   logic        phase_done;
   logic [15:0] car_cnt, car_nxt;
   logic [31:0] shift_q;
   logic [4:0]  bit_cnt;
   logic [7:0]  data_lo, data_hi, addr_lo, addr_hi;
   logic        done;
   logic        ctrl_wr, start_acc, busy;

   assign busy      = (state != IDLE);
   assign ctrl_wr   = chipselect && write && (address == 3'd0);
   assign start_acc = ctrl_wr && writedata[0] && !busy;

   function automatic logic is_mark(input state_t s);
      return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
   endfunction

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      phase_len = 20'd1;
      case (state)
         LEAD_MARK:  phase_len = LEAD_MARK_CYC;
         LEAD_SPACE: phase_len = LEAD_SPACE_CYC;
         BIT_MARK:   phase_len = BIT_MARK_CYC;
         BIT_SPACE:  phase_len = shift_q[0] ? ONE_SPACE_CYC : ZERO_SPACE_CYC;
         STOP_MARK:  phase_len = BIT_MARK_CYC;
         default:    phase_len = 20'd1;
      endcase
   end

   assign phase_done = (phase_cnt == phase_len - 20'd1);

   always_comb begin
      next_state = state;
      case (state)
         IDLE:       if (start_acc)  next_state = LEAD_MARK;
         LEAD_MARK:  if (phase_done) next_state = LEAD_SPACE;
         LEAD_SPACE: if (phase_done) next_state = BIT_MARK;
         BIT_MARK:   if (phase_done) next_state = BIT_SPACE;
         BIT_SPACE:  if (phase_done) next_state = (bit_cnt == 5'd31) ? STOP_MARK : BIT_MARK;
         STOP_MARK:  if (phase_done) next_state = IDLE;
         default:    next_state = IDLE;
      endcase
   end

   // Carrier restarts on every state change so each mark begins with a high cycle.
   always_comb begin
      car_nxt = 16'd0;
      if (next_state == state && car_cnt != 16'(CAR_DIV - 1))
         car_nxt = car_cnt + 16'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         state <= next_state;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_cnt <= '0;
         car_cnt   <= '0;
         shift_q   <= '0;
         bit_cnt   <= '0;
         oIR_env   <= 1'b0;
         oIR       <= 1'b0;
      end else begin
         if (next_state != state || state == IDLE) phase_cnt <= '0;
         else                                      phase_cnt <= phase_cnt + 20'd1;
         car_cnt <= car_nxt;
         oIR_env <= is_mark(next_state);
         oIR     <= is_mark(next_state) && (car_nxt < 16'(CAR_THR));
         if (start_acc) begin
            shift_q <= {data_hi, data_lo, addr_hi, addr_lo};
            bit_cnt <= '0;
         end else if (state == BIT_SPACE && phase_done) begin
            shift_q <= shift_q >> 1;
            bit_cnt <= bit_cnt + 5'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_lo <= '0;
         data_hi <= '0;
         addr_lo <= '0;
         addr_hi <= '0;
         done    <= 1'b0;
      end else begin
         if (chipselect && write) begin
            case (address)
               3'd1:    data_lo <= writedata;
               3'd2:    data_hi <= writedata;
               3'd3:    addr_lo <= writedata;
               3'd4:    addr_hi <= writedata;
               default: ;
            endcase
         end
         // Completion outranks a simultaneous clear.
         if (state == STOP_MARK && phase_done)
            done <= 1'b1;
         else if (start_acc || (ctrl_wr && writedata[1]))
            done <= 1'b0;
      end
   end

   always_comb begin
      readdata = 8'h00;
      if (chipselect && read) begin
         case (address)
            3'd0:    readdata = {6'b0, done, busy};
            3'd1:    readdata = data_lo;
            3'd2:    readdata = data_hi;
            3'd3:    readdata = addr_lo;
            3'd4:    readdata = addr_hi;
            default: readdata = 8'h00;
         endcase
      end
   end

   assign Done_Flag_o = done;

endmodule

// File: tb/tb_avalon_ir_encode.sv
// Directed bench for avalon_ir_encode with scaled timing: 2 MHz clock, short phases.
module tb_avalon_ir_encode;

   // 2 cycles/us; CAR_DIV = 2000000/38000 = 52, carrier high while count < 17.
   localparam int LM = 180, LS = 90, BM = 12, ZS = 12, OS = 34;
   localparam int CDIV = 52, CHI = 17, LIMIT = 1000;

   logic       clk, reset_n;
   logic [2:0] address;
   logic [7:0] writedata, readdata;
   logic       write, read, chipselect;
   logic       oIR, oIR_env, Done_Flag_o;

   int tests = 0;
   int fails = 0;

   avalon_ir_encode #(
      .CLK_FREQ(2000000), .CARRIER_HZ(38000),
      .LEAD_MARK_US(90), .LEAD_SPACE_US(45), .BIT_MARK_US(6),
      .ZERO_SPACE_US(6), .ONE_SPACE_US(17)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .writedata(writedata),
      .write(write), .read(read), .chipselect(chipselect), .readdata(readdata),
      .oIR(oIR), .oIR_env(oIR_env), .Done_Flag_o(Done_Flag_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic read_chk(input logic [2:0] a, input logic [7:0] exp, input string tag);
      chipselect = 1'b1; read = 1'b1; address = a;
      #1;
      check(tag, {24'h0, readdata}, {24'h0, exp});
      chipselect = 1'b0; read = 1'b0;
      #1;
   endtask

   // Counts cycles while oIR_env == lvl, checking the carrier pattern; optionally
   // drives a CTRL write during cycle poke_idx of the run.
   task automatic measure(input logic lvl, input int poke_idx, input logic [7:0] poke_data,
                          output int len, output bit car_ok);
      logic exp_ir;
      len = 0;
      car_ok = 1'b1;
      while (oIR_env === lvl && len < LIMIT) begin
         exp_ir = lvl && ((len % CDIV) < CHI);
         if (oIR !== exp_ir) car_ok = 1'b0;
         if (len == poke_idx) begin
            chipselect = 1'b1; write = 1'b1; address = 3'd0; writedata = poke_data;
         end else begin
            chipselect = 1'b0; write = 1'b0;
         end
         len++;
         @(negedge clk);
      end
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic run_frame(input logic [31:0] exp, input string tag, input int poke_bit,
                            input bit stop_clear, input int stop_at);
      int  len;
      bit  car_ok, all_car, marks_ok, spaces_ok;
      logic [31:0] payload;
      all_car = 1'b1; marks_ok = 1'b1; spaces_ok = 1'b1; payload = '0;
      measure(1'b1, -1, 8'h00, len, car_ok);
      check({tag, "_lead_mark"}, len, LM);
      check({tag, "_lead_carrier"}, {31'h0, car_ok}, 32'h1);
      measure(1'b0, -1, 8'h00, len, car_ok);
      check({tag, "_lead_space"}, len, LS);
      all_car &= car_ok;
      for (int b = 0; b < 32; b++) begin
         if (b == stop_at) return;
         measure(1'b1, (b == poke_bit) ? 0 : -1, 8'h01, len, car_ok);
         if (len != BM) marks_ok = 1'b0;
         all_car &= car_ok;
         if (b == poke_bit) read_chk(3'd0, 8'h01, {tag, "_busy_start_ignored"});
         measure(1'b0, -1, 8'h00, len, car_ok);
         if (len != ZS && len != OS) spaces_ok = 1'b0;
         payload[b] = (len == OS);
         all_car &= car_ok;
      end
      check({tag, "_payload"}, payload, exp);
      check({tag, "_marks_ok"}, {31'h0, marks_ok}, 32'h1);
      check({tag, "_spaces_ok"}, {31'h0, spaces_ok}, 32'h1);
      measure(1'b1, stop_clear ? BM - 1 : -1, 8'h02, len, car_ok);
      all_car &= car_ok;
      check({tag, "_stop_mark"}, len, BM);
      check({tag, "_carrier"}, {31'h0, all_car}, 32'h1);
      read_chk(3'd0, 8'h02, {tag, "_ctrl_done"});
      check({tag, "_done_o"}, {31'h0, Done_Flag_o}, 32'h1);
      check({tag, "_idle_env"}, {30'h0, oIR_env, oIR}, 32'h0);
   endtask

   initial begin
      reset_n = 1'b0; address = '0; writedata = '0;
      write = 1'b0; read = 1'b0; chipselect = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      check("rst_outputs", {29'h0, oIR, oIR_env, Done_Flag_o}, 32'h0);
      for (int a = 0; a < 8; a++) read_chk(3'(a), 8'h00, $sformatf("rst_read_%0d", a));

      bus_write(3'd3, 8'hFF);
      bus_write(3'd4, 8'h00);
      bus_write(3'd1, 8'hBA);
      bus_write(3'd2, 8'h45);
      bus_write(3'd6, 8'h55);
      read_chk(3'd1, 8'hBA, "rd_data_lo");
      read_chk(3'd2, 8'h45, "rd_data_hi");
      read_chk(3'd3, 8'hFF, "rd_addr_lo");
      read_chk(3'd4, 8'h00, "rd_addr_hi");
      read_chk(3'd6, 8'h00, "rd_unmapped");

      // Frame 1: start ignored while busy at bit 5.
      bus_write(3'd0, 8'h01);
      check("start_latency_env", {31'h0, oIR_env}, 32'h1);
      read_chk(3'd0, 8'h01, "f1_ctrl_busy");
      run_frame(32'h45BA00FF, "f1", 5, 1'b0, -1);

      bus_write(3'd0, 8'h02);
      read_chk(3'd0, 8'h00, "clear_done_ctrl");
      check("clear_done_o", {31'h0, Done_Flag_o}, 32'h0);

      // Frame 2: clear write coincides with completion; set must win.
      bus_write(3'd0, 8'h01);
      run_frame(32'h45BA00FF, "f2", -1, 1'b1, -1);

      // Start and clear together in IDLE: start accepted, done cleared.
      bus_write(3'd0, 8'h03);
      read_chk(3'd0, 8'h01, "start_clear_ctrl");
      check("start_clear_done_o", {31'h0, Done_Flag_o}, 32'h0);
      run_frame(32'h45BA00FF, "f3", -1, 1'b0, 10);
      check("f3_bit10_mark_env", {31'h0, oIR_env}, 32'h1);
      reset_n = 1'b0;
      #1;
      check("midrst_outputs", {29'h0, oIR, oIR_env, Done_Flag_o}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      for (int a = 0; a < 5; a++) read_chk(3'(a), 8'h00, $sformatf("midrst_read_%0d", a));
      repeat (20) @(negedge clk);
      check("midrst_stays_idle", {30'h0, oIR_env, oIR}, 32'h0);

      // Frame 4: fresh payload after reset.
      bus_write(3'd3, 8'h5A);
      bus_write(3'd4, 8'hC3);
      bus_write(3'd1, 8'h0F);
      bus_write(3'd2, 8'h81);
      bus_write(3'd0, 8'h01);
      run_frame(32'h810FC35A, "f4", -1, 1'b0, -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
